// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions.
//   fifo_entry_t    : one fetched instruction, {pc, inst}
//   INST_FIFO_DEPTH : default instruction buffer depth
package cpu_defs_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    localparam int INST_FIFO_DEPTH = 16;

endpackage

// File: rtl/inst_fifo_mem.sv
// Instruction buffer storage: DEPTH x fifo_entry_t register file.
// Ports:
//   clk           : clock, writes on posedge
//   we1/wa1/wd1   : write port 1 (enable, address, entry)
//   we2/wa2/wd2   : write port 2; never aliases port 1 when both enabled
//   ra1/rd1       : async read port 1
//   ra2/rd2       : async read port 2
// Storage is deliberately not reset.
module inst_fifo_mem
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH  = INST_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  fifo_entry_t       wd1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa2,
    input  fifo_entry_t       wd2,
    input  logic [ADDR_W-1:0] ra1,
    output fifo_entry_t       rd1,
    input  logic [ADDR_W-1:0] ra2,
    output fifo_entry_t       rd2
);

    fifo_entry_t mem [DEPTH];

    // One register per entry; the two write ports target distinct slots,
    // so the priority between them is never exercised.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk) begin
            if (we1 && wa1 == ADDR_W'(i))
                mem[i] <= wd1;
            else if (we2 && wa2 == ADDR_W'(i))
                mem[i] <= wd2;
        end
    end

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];

endmodule

// File: rtl/inst_fifo_dual.sv
// Dual-push / dual-pop instruction buffer between fetch and dual-issue decode.
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   flush                     : drop all entries (redirect/exception)
//   write_en1/2, write_pc1/2,
//   write_inst1/2             : up to two pushes per cycle; entry 2 needs entry 1
//   read_en1/2                : pop master / master+slave; read_en2 needs read_en1
//   master_*/slave_*          : show-ahead head and head+1 entries, zero when invalid
//   fifo_empty/almost_empty   : count == 0 / count == 1
//   fifo_full                 : fewer than two free slots
module inst_fifo_dual
    import cpu_defs_pkg::*;
#(
    parameter  int DEPTH  = INST_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        write_en1,
    input  logic        write_en2,
    input  logic [31:0] write_pc1,
    input  logic [31:0] write_inst1,
    input  logic [31:0] write_pc2,
    input  logic [31:0] write_inst2,
    input  logic        read_en1,
    input  logic        read_en2,
    output logic        master_valid,
    output logic [31:0] master_pc,
    output logic [31:0] master_inst,
    output logic        slave_valid,
    output logic [31:0] slave_pc,
    output logic [31:0] slave_inst,
    output logic        fifo_empty,
    output logic        fifo_almost_empty,
    output logic        fifo_full
);

    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] head, tail;
    logic [CNT_W-1:0]  count;

    logic        wr_one, wr_two, pop_one, pop_two;
    logic [1:0]  n_push, n_pop;
    fifo_entry_t rd_master, rd_slave;

    // Full is judged before this cycle's pop, so a popped full FIFO still refuses.
    assign wr_one  = write_en1 && !fifo_full;
    assign wr_two  = wr_one && write_en2;
    // Over-reads are clipped against the pre-edge count.
    assign pop_one = read_en1 && count >= CNT_W'(1);
    assign pop_two = pop_one && read_en2 && count >= CNT_W'(2);

    assign n_push = wr_two  ? 2'd2 : (wr_one  ? 2'd1 : 2'd0);
    assign n_pop  = pop_two ? 2'd2 : (pop_one ? 2'd1 : 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ADDR_W'(n_pop);
            tail  <= tail + ADDR_W'(n_push);
            count <= count + CNT_W'(n_push) - CNT_W'(n_pop);
        end
    end

    inst_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk (clk),
        .we1 (wr_one && rst_n && !flush),
        .wa1 (tail),
        .wd1 ('{pc: write_pc1, inst: write_inst1}),
        .we2 (wr_two && rst_n && !flush),
        .wa2 (tail + ADDR_W'(1)),
        .wd2 ('{pc: write_pc2, inst: write_inst2}),
        .ra1 (head),
        .rd1 (rd_master),
        .ra2 (head + ADDR_W'(1)),
        .rd2 (rd_slave)
    );

    assign master_valid      = count >= CNT_W'(1);
    assign slave_valid       = count >= CNT_W'(2);
    // Mask unwritten/stale storage so invalid slots read as zero.
    assign master_pc         = master_valid ? rd_master.pc   : '0;
    assign master_inst       = master_valid ? rd_master.inst : '0;
    assign slave_pc          = slave_valid  ? rd_slave.pc    : '0;
    assign slave_inst        = slave_valid  ? rd_slave.inst  : '0;
    assign fifo_empty        = count == '0;
    assign fifo_almost_empty = count == CNT_W'(1);
    assign fifo_full         = count > CNT_W'(DEPTH - 2);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(fifo_empty && fifo_full));
            assert (count <= CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_inst_fifo_dual.sv
module tb_inst_fifo_dual;
    import cpu_defs_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        write_en1 = 1'b0, write_en2 = 1'b0;
    logic [31:0] write_pc1 = '0, write_inst1 = '0, write_pc2 = '0, write_inst2 = '0;
    logic        read_en1 = 1'b0, read_en2 = 1'b0;
    logic        master_valid, slave_valid;
    logic [31:0] master_pc, master_inst, slave_pc, slave_inst;
    logic        fifo_empty, fifo_almost_empty, fifo_full;

    inst_fifo_dual #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .write_en1(write_en1), .write_en2(write_en2),
        .write_pc1(write_pc1), .write_inst1(write_inst1),
        .write_pc2(write_pc2), .write_inst2(write_inst2),
        .read_en1(read_en1), .read_en2(read_en2),
        .master_valid(master_valid), .master_pc(master_pc), .master_inst(master_inst),
        .slave_valid(slave_valid), .slave_pc(slave_pc), .slave_inst(slave_inst),
        .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    fifo_entry_t q[$];     // reference contents, oldest first
    logic [31:0] seq_pc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, "_mv"},    64'(master_valid),      64'(n >= 1));
        chk({tag, "_mpc"},   64'(master_pc),         n >= 1 ? 64'(q[0].pc)   : 64'd0);
        chk({tag, "_minst"}, 64'(master_inst),       n >= 1 ? 64'(q[0].inst) : 64'd0);
        chk({tag, "_sv"},    64'(slave_valid),       64'(n >= 2));
        chk({tag, "_spc"},   64'(slave_pc),          n >= 2 ? 64'(q[1].pc)   : 64'd0);
        chk({tag, "_sinst"}, 64'(slave_inst),        n >= 2 ? 64'(q[1].inst) : 64'd0);
        chk({tag, "_empty"}, 64'(fifo_empty),        64'(n == 0));
        chk({tag, "_aempt"}, 64'(fifo_almost_empty), 64'(n == 1));
        chk({tag, "_full"},  64'(fifo_full),         64'(n > DEPTH - 2));
    endtask

    // Drive one cycle, advance the model with pre-edge occupancy, check after the edge.
    task automatic step(input string tag, input logic rst, input logic fl,
                        input logic we1, input logic we2,
                        input fifo_entry_t e1, input fifo_entry_t e2,
                        input logic re1, input logic re2);
        int pre;
        rst_n = ~rst; flush = fl;
        write_en1 = we1; write_en2 = we2;
        write_pc1 = e1.pc; write_inst1 = e1.inst;
        write_pc2 = e2.pc; write_inst2 = e2.inst;
        read_en1 = re1; read_en2 = re2;
        @(posedge clk);
        pre = q.size();
        if (rst || fl) begin
            q.delete();
        end else begin
            if (re1 && pre >= 1) void'(q.pop_front());
            if (re1 && re2 && pre >= 2) void'(q.pop_front());
            if (we1 && pre <= DEPTH - 2) begin
                q.push_back(e1);
                if (we2) q.push_back(e2);
            end
        end
        #1;
        check_all(tag);
    endtask

    function automatic fifo_entry_t ent(input logic [31:0] pc, input logic [31:0] inst);
        fifo_entry_t e;
        e.pc = pc; e.inst = inst;
        return e;
    endfunction

    function automatic fifo_entry_t rnd_ent();
        return ent($urandom, $urandom);
    endfunction

    fifo_entry_t z;

    initial begin
        z = ent(32'h0, 32'h0);

        // 1: reset then idle
        step("rst", 1, 0, 0, 0, z, z, 0, 0);
        step("rst", 1, 0, 0, 0, z, z, 0, 0);
        step("idle", 0, 0, 0, 0, z, z, 0, 0);

        // 2: dual push, then dual pop
        step("t2_push", 0, 0, 1, 1, ent(32'hBFC00000, 32'h24080001),
             ent(32'hBFC00004, 32'h24090002), 0, 0);
        chk("t2_master_pc", 64'(master_pc), 64'hBFC00000);
        chk("t2_slave_pc",  64'(slave_pc),  64'hBFC00004);
        step("t2_pop", 0, 0, 0, 0, z, z, 1, 1);
        chk("t2_empty", 64'(fifo_empty), 64'd1);

        // 3: one entry, dual pop request clips to one
        step("t3_push", 0, 0, 1, 0, rnd_ent(), z, 0, 0);
        step("t3_pop", 0, 0, 0, 0, z, z, 1, 1);
        step("t3_over", 0, 0, 0, 0, z, z, 1, 1);
        chk("t3_empty", 64'(fifo_empty), 64'd1);

        // 4: fill to 14 (two slots still free, so not full), then 15 = full;
        // a dual push with a single pop on the full FIFO is dropped -> 14
        for (int i = 0; i < 7; i++)
            step("t4_fill", 0, 0, 1, 1, rnd_ent(), rnd_ent(), 0, 0);
        chk("t4_full14", 64'(fifo_full), 64'd0);
        step("t4_fill", 0, 0, 1, 0, rnd_ent(), z, 0, 0);
        chk("t4_full15", 64'(fifo_full), 64'd1);
        step("t4_drop", 0, 0, 1, 1, rnd_ent(), rnd_ent(), 1, 0);
        chk("t4_full14b", 64'(fifo_full), 64'd0);
        while (q.size() > 0)
            step("t4_drain", 0, 0, 0, 0, z, z, 1, 1);

        // 5: streaming with wrap; PCs must leave strictly sequential
        seq_pc = 32'h8000_0000;
        for (int i = 0; i < 40; i++) begin
            step("t5_stream", 0, 0, 1, 1, ent(32'h8000_0000 + 32'(i * 8), $urandom),
                 ent(32'h8000_0004 + 32'(i * 8), $urandom), 1, 1);
            if (master_valid) begin
                chk("t5_seq_m", 64'(master_pc), 64'(seq_pc));
                chk("t5_seq_s", 64'(slave_pc),  64'(seq_pc + 32'd4));
                seq_pc = seq_pc + 32'd8;
            end
        end
        step("t5_drain", 0, 0, 0, 0, z, z, 1, 1);

        // 6: flush at count 7 overrides write and read
        for (int i = 0; i < 3; i++)
            step("t6_fill", 0, 0, 1, 1, rnd_ent(), rnd_ent(), 0, 0);
        step("t6_fill", 0, 0, 1, 0, rnd_ent(), z, 0, 0);
        step("t6_flush", 0, 1, 1, 0, rnd_ent(), z, 1, 0);
        chk("t6_empty", 64'(fifo_empty), 64'd1);
        step("t6_after", 0, 0, 0, 0, z, z, 0, 0);

        // random traffic with occasional flush / reset
        for (int i = 0; i < 3000; i++) begin
            step("rand", $urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom),
                 rnd_ent(), rnd_ent(),
                 $urandom_range(0, 2) != 0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
